// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state
// encoding, default operand width and the bit-counter width helper.
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bit-counter width: enough to count WIDTH-1, but never zero bits wide.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Host-side handshake and operand/result bus of the serial adder.
// The host drives start and the operands; the adder returns busy/done and
// the held result.
interface serial_add_ctrl_if
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );

endinterface

// File: rtl/serial_add_ctrl_fa_cell.sv
// Single 1-bit full-adder cell; the only arithmetic in the serial adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  // Sum is the parity of the inputs, carry is their majority.
  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: adds two WIDTH-bit operands one bit per
// clock (LSB first) through a single full-adder cell, with a
// start/busy/done handshake that allows back-to-back additions.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_add_ctrl_if.slave   bus
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   res_sh_q, res_sh_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               fa_s;
  logic               fa_co;
  logic [WIDTH-1:0]   res_next;

  fa_cell u_fa (
    .a     (a_sh_q[0]),
    .b     (b_sh_q[0]),
    .c     (carry_q),
    .sum   (fa_s),
    .carry (fa_co)
  );

  // Result register shifted right with the new sum bit entering at the MSB;
  // written as a shift of the concatenation so that WIDTH=1 needs no slice.
  assign res_next = WIDTH'({fa_s, res_sh_q} >> 1);

  // Next-state and datapath control: load on accepted start, shift in RUN,
  // capture the final result on the edge that processes the last bit.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          a_sh_d   = bus.a;
          b_sh_d   = bus.b;
          carry_d  = bus.cin;
          res_sh_d = '0;
          cnt_d    = '0;
          state_d  = ST_RUN;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_RUN: begin
        res_sh_d = res_next;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        carry_d  = fa_co;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          sum_d   = res_next;
          cout_d  = fa_co;
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any in-flight addition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
    end
  end

  assign bus.busy = (state_q == ST_RUN);
  assign bus.done = (state_q == ST_DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed scenarios and random
// additions on an 8-bit instance, exhaustive sweeps on 4-bit and 1-bit
// instances, all compared against plain integer addition.
module tb_serial_add_ctrl;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  serial_add_ctrl_if #(.WIDTH(8)) bus8 ();
  serial_add_ctrl_if #(.WIDTH(4)) bus4 ();
  serial_add_ctrl_if #(.WIDTH(1)) bus1 ();

  serial_add_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_add_ctrl #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  serial_add_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  // 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: the answer is simply the integer sum of the operands.
  function automatic logic [8:0] model8(input logic [7:0] av, input logic [7:0] bv, input logic cv);
    return 9'(av) + 9'(bv) + 9'(cv);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present operands with start for one edge (the accepting edge).
  task automatic launch8(input logic [7:0] av, input logic [7:0] bv, input logic cv);
    bus8.start = 1'b1;
    bus8.a     = av;
    bus8.b     = bv;
    bus8.cin   = cv;
    step();
    bus8.start = 1'b0;
  endtask

  // Wait for done; cyc counts edges after the accepting edge.
  task automatic wait_done8(input int limit, output int cyc, output bit seen);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < limit) begin
      if (bus8.done) seen = 1'b1;
      else begin
        step();
        cyc++;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if ({bus8.busy, bus8.done, bus8.cout} !== 3'b000 || bus8.sum !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_w8: busy/done/cout=%b sum=%h expected 000 / 00", {bus8.busy, bus8.done, bus8.cout}, bus8.sum);
    end
    checks++;
    if ({bus4.busy, bus4.done, bus4.cout, bus4.sum} !== 7'b0 || {bus1.busy, bus1.done, bus1.cout, bus1.sum} !== 4'b0) begin
      errors++;
      $display("[TB] FAIL reset_w4_w1: w4=%b w1=%b expected all zero", {bus4.busy, bus4.done, bus4.cout, bus4.sum}, {bus1.busy, bus1.done, bus1.cout, bus1.sum});
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  // Walk an addition edge by edge checking busy/done timing and the result.
  task automatic run_timed8(input string name, input logic [7:0] av, input logic [7:0] bv, input logic cv);
    logic [8:0] exp;
    exp = model8(av, bv, cv);
    launch8(av, bv, cv);
    for (int k = 0; k <= 8; k++) begin
      checks++;
      if (bus8.busy !== (k < 8) || bus8.done !== (k == 8)) begin
        errors++;
        $display("[TB] FAIL %s_timing k=%0d: busy=%b done=%b expected busy=%b done=%b", name, k, bus8.busy, bus8.done, (k < 8), (k == 8));
      end
      if (k < 8) step();
    end
    checks++;
    if ({bus8.cout, bus8.sum} !== exp) begin
      errors++;
      $display("[TB] FAIL %s_result: got %h expected %h", name, {bus8.cout, bus8.sum}, exp);
    end
  endtask

  task automatic test_basic();
    run_timed8("basic_5a_3c", 8'h5A, 8'h3C, 1'b0);
    step();
  endtask

  task automatic test_back_to_back();
    run_timed8("b2b_first", 8'hFF, 8'h01, 1'b0);
    // Still in the done cycle: issue the next addition immediately.
    run_timed8("b2b_second", 8'hFF, 8'hFF, 1'b1);
    step();
  endtask

  task automatic test_ignore_start();
    int         dones;
    logic [8:0] got;
    dones = 0;
    got   = '0;
    launch8(8'h10, 8'h20, 1'b0);
    step();
    step();
    bus8.start = 1'b1;
    bus8.a     = 8'hAA;
    bus8.b     = 8'h55;
    step();
    bus8.start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus8.done) begin
        dones++;
        got = {bus8.cout, bus8.sum};
      end
      step();
    end
    checks++;
    if (dones !== 1) begin
      errors++;
      $display("[TB] FAIL ignore_done_count: got %0d expected 1", dones);
    end
    checks++;
    if (got !== 9'h030) begin
      errors++;
      $display("[TB] FAIL ignore_result: got %h expected 030", got);
    end
  endtask

  task automatic test_async_reset();
    int  dones;
    int  cyc;
    bit  seen;
    dones = 0;
    launch8(8'h12, 8'h34, 1'b0);
    step();
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus8.busy, bus8.done, bus8.cout} !== 3'b000 || bus8.sum !== 8'h00) begin
      errors++;
      $display("[TB] FAIL async_reset: busy/done/cout=%b sum=%h expected 000 / 00", {bus8.busy, bus8.done, bus8.cout}, bus8.sum);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      if (bus8.done) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("[TB] FAIL reset_no_done: got %0d done pulses expected 0", dones);
    end
    launch8(8'h03, 8'h04, 1'b1);
    wait_done8(40, cyc, seen);
    checks++;
    if (!seen || {bus8.cout, bus8.sum} !== 9'h008) begin
      errors++;
      $display("[TB] FAIL after_reset_result: seen=%b got %h expected 008", seen, {bus8.cout, bus8.sum});
    end
    step();
  endtask

  task automatic test_input_change();
    int cyc;
    int held_bad;
    held_bad = 0;
    cyc      = 0;
    launch8(8'h7F, 8'h01, 1'b0);
    while (!bus8.done && cyc < 40) begin
      bus8.a   = 8'($urandom);
      bus8.b   = 8'($urandom);
      bus8.cin = 1'($urandom);
      if ({bus8.cout, bus8.sum} !== 9'h008) held_bad++;
      step();
      cyc++;
    end
    checks++;
    if (held_bad !== 0) begin
      errors++;
      $display("[TB] FAIL hold_prev_sum: %0d cycles changed, expected 008 held", held_bad);
    end
    checks++;
    if (!bus8.done || cyc !== 8 || {bus8.cout, bus8.sum} !== 9'h080) begin
      errors++;
      $display("[TB] FAIL captured_operands: done=%b lat=%0d got %h expected lat 8 result 080", bus8.done, cyc, {bus8.cout, bus8.sum});
    end
    step();
  endtask

  task automatic test_random();
    logic [7:0] av, bv;
    logic       cv;
    int         cyc;
    bit         seen;
    for (int i = 0; i < 30; i++) begin
      av = 8'($urandom);
      bv = 8'($urandom);
      cv = 1'($urandom);
      launch8(av, bv, cv);
      wait_done8(40, cyc, seen);
      checks++;
      if (!seen || cyc !== 8 || {bus8.cout, bus8.sum} !== model8(av, bv, cv)) begin
        errors++;
        $display("[TB] FAIL random_%0d: seen=%b lat=%0d got %h expected lat 8 result %h", i, seen, cyc, {bus8.cout, bus8.sum}, model8(av, bv, cv));
      end
      if ($urandom_range(1, 0) == 0) step();
    end
    step();
  endtask

  task automatic test_width4_exhaustive();
    int cyc;
    int exp;
    for (int av = 0; av < 16; av++) begin
      for (int bv = 0; bv < 16; bv++) begin
        for (int cv = 0; cv < 2; cv++) begin
          exp        = av + bv + cv;
          bus4.start = 1'b1;
          bus4.a     = 4'(av);
          bus4.b     = 4'(bv);
          bus4.cin   = 1'(cv);
          step();
          bus4.start = 1'b0;
          cyc = 0;
          while (!bus4.done && cyc < 20) begin
            step();
            cyc++;
          end
          checks++;
          if (!bus4.done || cyc !== 4 || {bus4.cout, bus4.sum} !== 5'(exp)) begin
            errors++;
            $display("[TB] FAIL w4 a=%0d b=%0d c=%0d: done=%b lat=%0d got %h expected lat 4 result %h", av, bv, cv, bus4.done, cyc, {bus4.cout, bus4.sum}, 5'(exp));
          end
        end
      end
    end
    step();
  endtask

  task automatic test_width1_exhaustive();
    int cyc;
    int exp;
    for (int av = 0; av < 2; av++) begin
      for (int bv = 0; bv < 2; bv++) begin
        for (int cv = 0; cv < 2; cv++) begin
          exp        = av + bv + cv;
          bus1.start = 1'b1;
          bus1.a     = 1'(av);
          bus1.b     = 1'(bv);
          bus1.cin   = 1'(cv);
          step();
          bus1.start = 1'b0;
          cyc = 0;
          while (!bus1.done && cyc < 20) begin
            step();
            cyc++;
          end
          checks++;
          if (!bus1.done || cyc !== 1 || {bus1.cout, bus1.sum} !== 2'(exp)) begin
            errors++;
            $display("[TB] FAIL w1 a=%0d b=%0d c=%0d: done=%b lat=%0d got %b expected lat 1 result %b", av, bv, cv, bus1.done, cyc, {bus1.cout, bus1.sum}, 2'(exp));
          end
        end
      end
    end
    step();
  endtask

  // Scenario sequence
  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_ignore_start();
    test_async_reset();
    test_input_change();
    test_random();
    test_width4_exhaustive();
    test_width1_exhaustive();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog in case a scenario never completes
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] timeout");
  end

endmodule
